sm83_pch_bus_dec: RTL
=====================

SM83_PCH_BUS_DEC -- requirements
Module: sm83_pch_bus_dec

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the number of bits in the precharged bus.
REQ-002 The module SHALL have parameter NDRV, default 4, meaning the number of pull-down driver channels.
REQ-003 The module SHALL have parameter DECAY, default 0, meaning the number of hold cycles before charge leaks away (0 = never).
REQ-004 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  is the reset: synchronous, active-low.
REQ-006 Port pch_n  input  1  is the precharge request, active-low.
REQ-007 Port drv_en  input  NDRV  holds the per-channel driver enables.
REQ-008 Port drv_data  input  NDRV*WIDTH  holds the driver data, channel k in bits [k*WIDTH +: WIDTH]; a 0 discharges that bit.
REQ-009 Port node  output  WIDTH  is the registered dynamic bus state.
REQ-010 Port y  output  WIDTH  is the decoded inverted bus, ~node.
REQ-011 Port contention  output  1  is set when precharge and a discharging driver coincide.
REQ-012 Port decayed  output  1  is set when the bus has leaked since the last precharge.

Function
REQ-013 The FSM SHALL have states IDLE, PCH, EVAL and HOLD.
REQ-014 When pch_n=0, the FSM SHALL enter PCH and node SHALL become all-ones on the next edge, regardless of drivers.
REQ-015 When pch_n=1 and any drv_en bit is set, the FSM SHALL enter EVAL and node SHALL become node AND (AND of drv_data over all enabled channels).
REQ-016 Evaluation SHALL be monotonic: a discharged bit SHALL remain 0 until the next precharge.
REQ-017 When pch_n=1 and drv_en=0, the FSM SHALL enter HOLD and node SHALL be retained.
REQ-018 The leak counter SHALL increment each HOLD cycle; it SHALL saturate at DECAY.
REQ-019 The leak counter SHALL clear on PCH or EVAL.
REQ-020 When DECAY>0 and the counter reaches DECAY, node SHALL become all-zeros on the next edge and decayed SHALL be set to 1.
REQ-021 decayed SHALL stay set until the next precharge; it SHALL never be set when DECAY=0.
REQ-022 contention SHALL be a registered flag, 1 for exactly the cycle after an edge where pch_n=0 and some enabled channel had a 0 data bit; precharge SHALL win.
REQ-023 y SHALL equal ~node combinationally, giving one clock of latency from inputs to y.
REQ-024 From IDLE (post-reset), drivers SHALL evaluate against the reset node value.

Reset
REQ-025 On reset_n=0 at a clock edge: node SHALL be all-ones, y all-zeros, contention 0, decayed 0, counter 0 and state IDLE.
REQ-026 Reset SHALL override all other inputs, including mid-EVAL and mid-HOLD.
REQ-027 Outputs SHALL NOT be X after the first reset edge.

Structure
REQ-028 The FSM state enum and the counter-width function clog2(DECAY+1) (minimum 1 bit) SHALL live in shared package sm83_pch_pkg.
REQ-029 A per-bit sub-module sm83_pch_bus_bit SHALL hold one node bit with its precharge/discharge/leak logic and SHALL be instantiated WIDTH times.
REQ-030 The FSM, leak counter and flags SHALL be in the top module.

Verification
REQ-031 Scenario, WIDTH=8: reset, pch_n=0 one cycle -> node=8'hFF, y=8'h00.
REQ-032 Scenario, WIDTH=8: after precharge, enable ch0=8'hF0 and ch2=8'h3C in the same cycle -> node=8'h30, y=8'hCF next cycle; then ch1=8'hFF -> node stays 8'h30.
REQ-033 Scenario, WIDTH=8: pch_n=0 with ch1 enabled, data 8'h7F -> node=8'hFF, contention=1 for one cycle, then 0.
REQ-034 Scenario, DECAY=3: precharge, then 3 idle cycles -> node=8'h00 and decayed=1 after the 3rd hold edge; then precharge -> decayed=0.
REQ-035 Scenario, DECAY=0: 100 idle cycles after precharge -> node=8'hFF and decayed=0 throughout.
REQ-036 Scenario: reset_n=0 while EVAL has discharged node to 8'h0F -> node=8'hFF, flags 0, state IDLE on that edge.

Source files
------------

// File: rtl/sm83_pch_pkg.sv
// Shared types and helpers for the SM83-style precharged bus decoder.
package sm83_pch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCH  = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } pch_state_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sm83_pch_bus_bit.sv
// One dynamic bus node: precharge wins, then leak or discharge, otherwise the charge holds.
module sm83_pch_bus_bit
    import sm83_pch_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic pch,
    input  logic dis,
    input  logic leak,
    output logic node
);

    logic node_q;
    logic node_d;

    always_comb begin
        node_d = node_q;
        if (pch) begin
            node_d = 1'b1;
        end else if (leak || dis) begin
            node_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            node_q <= 1'b1;
        end else begin
            node_q <= node_d;
        end
    end

    assign node = node_q;

endmodule

// File: rtl/sm83_pch_bus_dec.sv
// Precharged wired-AND bus with pull-down drivers, optional charge leak and a contention flag.
module sm83_pch_bus_dec
    import sm83_pch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDRV  = 4,
    parameter int DECAY = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pch_n,
    input  logic [NDRV-1:0]       drv_en,
    input  logic [NDRV*WIDTH-1:0] drv_data,
    output logic [WIDTH-1:0]      node,
    output logic [WIDTH-1:0]      y,
    output logic                  contention,
    output logic                  decayed
);

    localparam int CW = clog2(DECAY + 1);
    localparam logic [CW-1:0] DECAY_C = CW'(DECAY);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    pch_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_base;
    logic           contention_q, contention_d;
    logic           decayed_q, decayed_d;
    logic [WIDTH-1:0] dis_mask;
    logic           pch, eval, hold, leak;

    always_comb begin
        dis_mask = '0;
        for (int k = 0; k < NDRV; k++) begin
            if (drv_en[k]) begin
                dis_mask = dis_mask | ~drv_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign pch  = !pch_n;
    assign eval = pch_n && (|drv_en);
    assign hold = pch_n && !(|drv_en);

    // The leak count only carries over between consecutive HOLD cycles.
    always_comb begin
        state_d      = HOLD;
        cnt_base     = (state_q == HOLD) ? cnt_q : '0;
        cnt_d        = '0;
        leak         = 1'b0;
        decayed_d    = decayed_q;
        contention_d = pch && (|dis_mask);
        if (pch) begin
            state_d = PCH;
        end else if (eval) begin
            state_d = EVAL;
        end
        if (hold && (DECAY > 0)) begin
            cnt_d = (cnt_base == DECAY_C) ? cnt_base : cnt_base + ONE_C;
            leak  = (cnt_d == DECAY_C);
        end
        if (pch) begin
            decayed_d = 1'b0;
        end else if (leak) begin
            decayed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            contention_q <= 1'b0;
            decayed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            contention_q <= contention_d;
            decayed_q    <= decayed_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sm83_pch_bus_bit u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pch     (pch),
            .dis     (dis_mask[i]),
            .leak    (leak),
            .node    (node[i])
        );
    end

    assign y          = ~node;
    assign contention = contention_q;
    assign decayed    = decayed_q;

endmodule
